// File: rtl/data_mem_responder.sv
// Memory-stage data RAM responder: fixed wait states, hazard stall, error flagging.
// Optional macro DMEM_SUBWORD_EN enables RV32I byte/halfword loads and stores.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [2:0]        MemSizeM,
    output logic              MemStallM,
    output logic [31:0]       ReadDataM,
    output logic              MemErrM
);
    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state, w_next_state;
    logic [CNT_W-1:0]    r_cnt, w_next_cnt;
    logic                r_rd, r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_req, w_in_idle, w_stall_c, w_access;
    logic                w_rd, w_wr, w_oor, w_misal, w_bad_size, w_err;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_wdata, w_word, w_load, w_wmerge;
    logic [IDX_W-1:0]    w_widx;

    assign w_req     = MemReadM | MemWriteM;
    assign w_in_idle = (r_state == S_IDLE);

    // In IDLE the live request is used (needed when WAIT_CYCLES==1), otherwise the latched copy.
    assign w_rd    = w_in_idle ? MemReadM   : r_rd;
    assign w_wr    = w_in_idle ? MemWriteM  : r_wr;
    assign w_addr  = w_in_idle ? ALUResultM : r_addr;
    assign w_wdata = w_in_idle ? WriteDataM : r_wdata;

    assign w_widx = w_addr[ADDR_W-1:2];
    assign w_oor  = (w_widx >= IDX_W'(DEPTH_WORDS));
    assign w_word = r_mem[w_widx[RAM_AW-1:0]];

`ifdef DMEM_SUBWORD_EN
    logic [2:0]  r_size;
    logic [2:0]  w_size;
    logic [3:0]  w_be;
    logic [4:0]  w_lane_sh;
    logic [31:0] w_shifted, w_store_sh, w_mask;

    assign w_size     = w_in_idle ? MemSizeM : r_size;
    assign w_lane_sh  = {w_addr[1:0], 3'b000};
    assign w_shifted  = w_word >> w_lane_sh;
    assign w_store_sh = w_wdata << w_lane_sh;
    assign w_mask     = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_wmerge   = (w_word & ~w_mask) | (w_store_sh & w_mask);

    // funct3 decode: lane enables for stores, extension for loads, illegal sizes flagged
    always_comb begin
        w_bad_size = 1'b0;
        w_misal    = 1'b0;
        w_be       = 4'b0000;
        w_load     = 32'h0;
        case (w_size)
            3'b000: begin
                w_be   = 4'b0001 << w_addr[1:0];
                w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            3'b001: begin
                w_misal = w_addr[0];
                w_be    = 4'b0011 << w_addr[1:0];
                w_load  = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            3'b010: begin
                w_misal = (w_addr[1:0] != 2'b00);
                w_be    = 4'b1111;
                w_load  = w_word;
            end
            3'b100: begin
                w_bad_size = w_wr;
                w_load     = {24'h0, w_shifted[7:0]};
            end
            3'b101: begin
                w_bad_size = w_wr;
                w_misal    = w_addr[0];
                w_load     = {16'h0, w_shifted[15:0]};
            end
            default: w_bad_size = 1'b1;
        endcase
    end
`else
    logic w_unused_size;

    assign w_unused_size = ^MemSizeM;
    assign w_bad_size    = 1'b0;
    assign w_misal       = (w_addr[1:0] != 2'b00);
    assign w_load        = w_word;
    assign w_wmerge      = w_wdata;
`endif

    assign w_err = (w_rd & w_wr) | w_oor | w_misal | w_bad_size;

    // Next-state, counter and stall decode; w_access marks the edge that enters RESP
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall_c    = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_stall_c  = 1'b1;
                    w_next_cnt = CNT_W'(1);
                    if (WAIT_CYCLES > 1) begin
                        w_next_state = S_WAIT;
                    end else begin
                        w_next_state = S_RESP;
                        w_access     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                w_stall_c = 1'b1;
                if (r_cnt >= CNT_LAST) begin
                    w_next_state = S_RESP;
                    w_access     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign MemStallM = rst & w_stall_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
`ifdef DMEM_SUBWORD_EN
            r_size    <= '0;
`endif
            ReadDataM <= '0;
            MemErrM   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_in_idle && w_req) begin
                r_rd    <= MemReadM;
                r_wr    <= MemWriteM;
                r_addr  <= ALUResultM;
                r_wdata <= WriteDataM;
`ifdef DMEM_SUBWORD_EN
                r_size  <= MemSizeM;
`endif
            end
            MemErrM <= w_access & w_err;
            if (w_access) begin
                if (w_err) begin
                    ReadDataM <= '0;
                end else if (w_rd) begin
                    ReadDataM <= w_load;
                end
            end
        end
    end

    // RAM is not reset; a write is suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (rst && w_access && w_wr && !w_err) begin
            r_mem[w_widx[RAM_AW-1:0]] <= w_wmerge;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed loads/stores, error cases, reset abort.
module tb_data_mem_responder;
    localparam int unsigned WC = 2;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic [2:0]  MemSizeM = 3'b010;
    logic        MemStallM;
    logic [31:0] ReadDataM;
    logic        MemErrM;

    int   n_checks = 0;
    int   n_errors = 0;
    int   stall_run = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .ADDR_W     (32),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReadM  (MemReadM),
        .MemWriteM (MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .MemSizeM  (MemSizeM),
        .MemStallM (MemStallM),
        .ReadDataM (ReadDataM),
        .MemErrM   (MemErrM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // A response is the first non-stalled cycle after a stall run
    always @(negedge clk) begin
        if (!rst) begin
            stall_run = 0;
        end else if (MemStallM) begin
            stall_run++;
        end else begin
            if (stall_run != 0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'(stall_run), 32'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("resp_err", {31'h0, MemErrM}, {31'h0, mon_e.err});
                    chk("resp_rdata", ReadDataM, mon_e.rdata);
                    chk("stall_len", 32'(stall_run), 32'(WC));
                end
            end else begin
                chk("idle_err", {31'h0, MemErrM}, 32'h0);
            end
            stall_run = 0;
        end
    end

    task automatic idle(input int n);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one access, hold it until the response cycle has passed; scr perturbs inputs in WAIT
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size,
                       input logic eerr, input logic [31:0] erd, input bit scr);
        exp_t e;
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = addr;
        WriteDataM = wdata;
        MemSizeM   = size;
        e.err      = eerr;
        e.rdata    = erd;
        sb_q.push_back(e);
        for (int i = 0; i < int'(WC) + 1; i++) begin
            @(posedge clk);
            #1;
            if (scr && i == 0) begin
                ALUResultM = ~addr;
                WriteDataM = ~wdata;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, MemStallM}, 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_err", {31'h0, MemErrM}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        txn(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 1'b0, 32'h0,        1'b0);
        txn(1'b1, 1'b0, 32'h10,  32'h0,        3'b010, 1'b0, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 1'b0, 32'h12,  32'h0,        3'b010, 1'b1, 32'h0,        1'b0);
        txn(1'b1, 1'b0, 32'h10,  32'h0,        3'b010, 1'b0, 32'hDEADBEEF, 1'b0);
        idle(2);
        txn(1'b0, 1'b1, 32'h0,   32'h12345678, 3'b010, 1'b0, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 1'b1, 32'h400, 32'h1,        3'b010, 1'b1, 32'h0,        1'b0);
        txn(1'b1, 1'b0, 32'h0,   32'h0,        3'b010, 1'b0, 32'h12345678, 1'b0);
        txn(1'b1, 1'b1, 32'h10,  32'h0BADF00D, 3'b010, 1'b1, 32'h0,        1'b0);
        txn(1'b1, 1'b0, 32'h10,  32'h0,        3'b010, 1'b0, 32'hDEADBEEF, 1'b1);
        txn(1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 3'b010, 1'b0, 32'hDEADBEEF, 1'b1);
        txn(1'b1, 1'b0, 32'h3FC, 32'h0,        3'b010, 1'b0, 32'hA5A5A5A5, 1'b0);
        txn(1'b0, 1'b1, 32'h3FE, 32'h77777777, 3'b010, 1'b1, 32'h0,        1'b0);
        txn(1'b1, 1'b0, 32'h3FC, 32'h0,        3'b010, 1'b0, 32'hA5A5A5A5, 1'b0);
        idle(1);
        txn(1'b0, 1'b1, 32'h20,  32'hCAFEF00D, 3'b010, 1'b0, 32'hA5A5A5A5, 1'b0);

        // Reset during WAIT aborts the store and clears outputs at once
        MemWriteM  = 1'b1;
        ALUResultM = 32'h20;
        WriteDataM = 32'h5;
        MemSizeM   = 3'b010;
        @(posedge clk);
        #1;
        chk("wait_stall", {31'h0, MemStallM}, 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_stall", {31'h0, MemStallM}, 32'h0);
        chk("abort_rdata", ReadDataM, 32'h0);
        chk("abort_err", {31'h0, MemErrM}, 32'h0);
        MemWriteM = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        txn(1'b1, 1'b0, 32'h20,  32'h0,        3'b010, 1'b0, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_SUBWORD_EN
        txn(1'b0, 1'b1, 32'h11,  32'h00000080, 3'b000, 1'b0, 32'hCAFEF00D, 1'b0);
        txn(1'b1, 1'b0, 32'h10,  32'h0,        3'b010, 1'b0, 32'hDEAD80EF, 1'b0);
        txn(1'b1, 1'b0, 32'h11,  32'h0,        3'b000, 1'b0, 32'hFFFFFF80, 1'b0);
        txn(1'b1, 1'b0, 32'h11,  32'h0,        3'b100, 1'b0, 32'h00000080, 1'b0);
        txn(1'b1, 1'b0, 32'h12,  32'h0,        3'b001, 1'b0, 32'hFFFFDEAD, 1'b0);
        txn(1'b1, 1'b0, 32'h12,  32'h0,        3'b101, 1'b0, 32'h0000DEAD, 1'b0);
        txn(1'b1, 1'b0, 32'h11,  32'h0,        3'b001, 1'b1, 32'h0,        1'b0);
        txn(1'b0, 1'b1, 32'h10,  32'hFFFF1234, 3'b001, 1'b0, 32'h0,        1'b0);
        txn(1'b1, 1'b0, 32'h10,  32'h0,        3'b010, 1'b0, 32'hDEAD1234, 1'b0);
        txn(1'b1, 1'b0, 32'h10,  32'h0,        3'b011, 1'b1, 32'h0,        1'b0);
`endif

        idle(4);
        chk("queue_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
